// File: rtl/bram_port_arbiter.sv
// Two-master arbiter sharing one single-port BRAM between picorv32 (port 0) and a loader/DMA (port 1).
// Define BRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module bram_port_arbiter #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  m0_valid,
   input  logic [31:0]           m0_addr,
   input  logic [31:0]           m0_wdata,
   input  logic [3:0]            m0_wstrb,
   output logic                  m0_ready,
   output logic [31:0]           m0_rdata,
   input  logic                  m1_valid,
   input  logic [31:0]           m1_addr,
   input  logic [31:0]           m1_wdata,
   input  logic [3:0]            m1_wstrb,
   output logic                  m1_ready,
   output logic [31:0]           m1_rdata,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [31:0]           bram_din,
   output logic [3:0]            bram_we,
   input  logic [31:0]           bram_dout,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                  state, state_nxt;
   logic                    grant, grant_nxt;
   logic                    win;
   logic [31:0]             sel_addr;
   logic [31:0]             sel_wdata;
   logic [3:0]              sel_wstrb;
   logic                    sel_oor;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [31:0]             din_nxt;
   logic [3:0]              we_nxt;
   logic                    m0_ready_nxt, m1_ready_nxt;
   logic [31:0]             m0_rdata_nxt, m1_rdata_nxt;
   logic                    busy_nxt;
   logic                    unused_addr_bits;

`ifdef BRAM_ARB_RR_EN
   logic last_grant;

   // On contention the port that was not granted last wins; resets as if port 1 was last.
   assign win = (m0_valid && m1_valid) ? ~last_grant : ~m0_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         last_grant <= 1'b1;
      else if (state == IDLE && (m0_valid || m1_valid))
         last_grant <= win;
   end
`else
   assign win = ~m0_valid;
`endif

   assign sel_addr         = win ? m1_addr  : m0_addr;
   assign sel_wdata        = win ? m1_wdata : m0_wdata;
   assign sel_wstrb        = win ? m1_wstrb : m0_wstrb;
   assign sel_oor          = |sel_addr[31:ADDR_WIDTH+2];
   assign unused_addr_bits = ^sel_addr[1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Out-of-range requests skip the BRAM entirely and answer with zero data.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      addr_nxt     = bram_addr;
      din_nxt      = bram_din;
      we_nxt       = 4'b0000;
      m0_ready_nxt = 1'b0;
      m1_ready_nxt = 1'b0;
      m0_rdata_nxt = m0_rdata;
      m1_rdata_nxt = m1_rdata;
      case (state)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               grant_nxt = win;
               if (sel_oor) begin
                  state_nxt = RESP;
                  if (win) begin
                     m1_ready_nxt = 1'b1;
                     m1_rdata_nxt = 32'h0;
                  end else begin
                     m0_ready_nxt = 1'b1;
                     m0_rdata_nxt = 32'h0;
                  end
               end else begin
                  state_nxt = ISSUE;
                  addr_nxt  = sel_addr[ADDR_WIDTH+1:2];
                  din_nxt   = sel_wdata;
                  we_nxt    = sel_wstrb;
               end
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            state_nxt = RESP;
            if (grant) begin
               m1_ready_nxt = 1'b1;
               m1_rdata_nxt = bram_dout;
            end else begin
               m0_ready_nxt = 1'b1;
               m0_rdata_nxt = bram_dout;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         grant     <= 1'b0;
         bram_addr <= '0;
         bram_din  <= 32'h0;
         bram_we   <= 4'b0000;
         m0_ready  <= 1'b0;
         m1_ready  <= 1'b0;
         m0_rdata  <= 32'h0;
         m1_rdata  <= 32'h0;
         busy      <= 1'b0;
      end else begin
         grant     <= grant_nxt;
         bram_addr <= addr_nxt;
         bram_din  <= din_nxt;
         bram_we   <= we_nxt;
         m0_ready  <= m0_ready_nxt;
         m1_ready  <= m1_ready_nxt;
         m0_rdata  <= m0_rdata_nxt;
         m1_rdata  <= m1_rdata_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed testbench for bram_port_arbiter with a read-old, byte-write BRAM model.
module tb_bram_port_arbiter;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic          m0_valid, m1_valid;
   logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]    m0_wstrb, m1_wstrb;
   logic          m0_ready, m1_ready;
   logic [31:0]   m0_rdata, m1_rdata;
   logic [AW-1:0] bram_addr;
   logic [31:0]   bram_din;
   logic [3:0]    bram_we;
   logic [31:0]   bram_dout;
   logic          busy;

   logic          preload;
   logic [31:0]   mem [0:255];

   int checks = 0;
   int passes = 0;

   bram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
      .bram_dout(bram_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] initWord(input int i);
      case (i)
         2:       return 32'hAAAAAAAA;
         4:       return 32'h12345678;
         5:       return 32'hDEADBEEF;
         default: return 32'hC0DE0000 | i;
      endcase
   endfunction

   // Registered read returns the pre-write word, matching the target BRAM.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem[i] <= initWord(i);
         bram_dout <= 32'h0;
      end else begin
         bram_dout <= mem[bram_addr];
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input int port, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      if (port == 0) begin
         m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
      end else begin
         m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
      end
   endtask

   task automatic dropValid(input int port);
      if (port == 0) m0_valid = 1'b0;
      else           m1_valid = 1'b0;
   endtask

   // One port-0 read with a bounded wait; ready must land three edges after the request.
   task automatic doRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      int lat;
      int sawM1;
      lat   = 0;
      sawM1 = 0;
      applyStimulus(0, addr, 32'h0, 4'b0000);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (m1_ready) sawM1 = 1;
         if (m0_ready) begin
            lat = c;
            break;
         end
      end
      checkOutput({tag, "_lat"}, lat, 3);
      checkOutput({tag, "_rdata"}, m0_rdata, exp);
      checkOutput({tag, "_m1rdy"}, sawM1, 0);
      dropValid(0);
      step();
      checkOutput({tag, "_rdyoff"}, m0_ready, 1'b0);
   endtask

   int r0, r1, first, both;

   initial begin
      resetn   = 1'b0;
      preload  = 1'b1;
      m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
      step(); step(); step();

      checkOutput("rst_busy",   busy,      1'b0);
      checkOutput("rst_m0rdy",  m0_ready,  1'b0);
      checkOutput("rst_m1rdy",  m1_ready,  1'b0);
      checkOutput("rst_we",     bram_we,   4'h0);
      checkOutput("rst_addr",   bram_addr, 8'h00);
      checkOutput("rst_din",    bram_din,  32'h0);
      checkOutput("rst_m0data", m0_rdata,  32'h0);
      preload = 1'b0;
      resetn  = 1'b1;
      step();

      // Single read of word 5
      applyStimulus(0, 32'h14, 32'h0, 4'h0);
      step();
      checkOutput("rd_addr",  bram_addr, 8'd5);
      checkOutput("rd_we1",   bram_we,   4'h0);
      checkOutput("rd_busy",  busy,      1'b1);
      checkOutput("rd_rdy1",  m0_ready,  1'b0);
      step();
      checkOutput("rd_we2",   bram_we,   4'h0);
      checkOutput("rd_rdy2",  m0_ready,  1'b0);
      step();
      checkOutput("rd_rdy3",  m0_ready,  1'b1);
      checkOutput("rd_data",  m0_rdata,  32'hDEADBEEF);
      checkOutput("rd_m1rdy", m1_ready,  1'b0);
      dropValid(0);
      step();
      checkOutput("rd_rdy4",  m0_ready,  1'b0);
      checkOutput("rd_idle",  busy,      1'b0);

      // Byte write from port 1 onto word 2
      applyStimulus(1, 32'h08, 32'h11223344, 4'b0010);
      step();
      checkOutput("wr_we1",   bram_we,   4'b0010);
      checkOutput("wr_addr",  bram_addr, 8'd2);
      checkOutput("wr_din",   bram_din,  32'h11223344);
      step();
      checkOutput("wr_we2",   bram_we,   4'h0);
      step();
      checkOutput("wr_rdy",   m1_ready,  1'b1);
      checkOutput("wr_old",   m1_rdata,  32'hAAAAAAAA);
      checkOutput("wr_m0rdy", m0_ready,  1'b0);
      dropValid(1);
      step();
      checkOutput("wr_rdyoff", m1_ready, 1'b0);
      checkOutput("wr_mem",    mem[2],   32'hAAAA33AA);
      doRead("wr_rb", 32'h08, 32'hAAAA33AA);

      // Out-of-range read completes immediately with zero data
      applyStimulus(0, 32'h00000400, 32'h0, 4'h0);
      step();
      checkOutput("oor_rdy",  m0_ready, 1'b1);
      checkOutput("oor_data", m0_rdata, 32'h0);
      checkOutput("oor_busy", busy,     1'b1);
      checkOutput("oor_we",   bram_we,  4'h0);
      dropValid(0);
      step();
      checkOutput("oor_rdyoff", m0_ready, 1'b0);
      checkOutput("oor_idle",   busy,     1'b0);

      // Both ports requesting continuously for 16 edges
      r0 = 0; r1 = 0; first = -1; both = 0;
      applyStimulus(0, 32'h14, 32'h0, 4'h0);
      applyStimulus(1, 32'h0C, 32'h0, 4'h0);
      for (int c = 0; c < 16; c++) begin
         step();
         if (m0_ready) begin r0++; if (first < 0) first = 0; end
         if (m1_ready) begin r1++; if (first < 0) first = 1; end
         if (m0_ready && m1_ready) both++;
      end
      dropValid(0);
      dropValid(1);
`ifdef BRAM_ARB_RR_EN
      checkOutput("ct_m0cnt", r0,    2);
      checkOutput("ct_m1cnt", r1,    2);
      checkOutput("ct_first", first, 1);
`else
      checkOutput("ct_m0cnt", r0,    4);
      checkOutput("ct_m1cnt", r1,    0);
      checkOutput("ct_first", first, 0);
`endif
      checkOutput("ct_both", both, 0);
      step();
      checkOutput("ct_idle", busy, 1'b0);

      // Reset asserted while a full-word write sits in ISSUE
      applyStimulus(1, 32'h10, 32'hFFFFFFFF, 4'hF);
      step();
      checkOutput("rs_we_issue", bram_we, 4'hF);
      #2 resetn = 1'b0;
      #1;
      checkOutput("rs_we",     bram_we,   4'h0);
      checkOutput("rs_busy",   busy,      1'b0);
      checkOutput("rs_addr",   bram_addr, 8'h00);
      checkOutput("rs_din",    bram_din,  32'h0);
      checkOutput("rs_m1data", m1_rdata,  32'h0);
      dropValid(1);
      step();
      step();
      checkOutput("rs_mem", mem[4], 32'h12345678);
      resetn = 1'b1;
      step();
      checkOutput("rs_idle",  busy,     1'b0);
      checkOutput("rs_m1rdy", m1_ready, 1'b0);
      doRead("rs_rb", 32'h10, 32'h12345678);

      // Sixteen back-to-back reads from port 0
      for (int i = 0; i < 16; i++)
         doRead($sformatf("b2b%0d", i), i * 4, (i == 2) ? 32'hAAAA33AA : initWord(i));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
